// File: rtl/video_crtc_prog.sv
// -----------------------------------------------------------------------------
// video_crtc_prog
//   Parametrised, run-time-programmable CRTC timing and address generator.
//   Produces sync/blank timing, the character address and row address for the
//   font/VRAM pipeline, a frame-end strobe, blink phase and hardware cursor.
//   Character height, row stride and start address are shadowed so they only
//   change during vertical blank; double-scan and cursor controls act live.
//
//   Optional feature macro: VIDEO_CRTC_LPEN_EN (light-pen address latch).
//
// Ports:
//   iClk, iRstN        pixel clock, async active-low reset
//   iCharH             character height-1 in scanlines
//   iStride            address increment per character row
//   iStartAddr         frame start address (hardware scroll)
//   iDblScan           show every logical line twice
//   iCursorAddr/Start/End/Mode  cursor position, scanline range, blink mode
//   iLpen, iLpenClr    light-pen strobe and latch clear
//   oAddr, oRA, oDA    character address, row address, dot address
//   oHs, oVs, oBlank   sync and blanking
//   oRetrace           one-cycle frame-end strobe
//   oCursor, oBlink    cursor active, slow attribute blink phase
//   oLpenAddr/Valid    latched light-pen address and latch-full flag
// -----------------------------------------------------------------------------
module video_crtc_prog #(
    parameter int          H_VIS      = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_VIS      = 400,
    parameter int          V_FP       = 12,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 35,
    parameter logic        H_POL      = 1'b0,
    parameter logic        V_POL      = 1'b1,
    parameter int          ADDR_W     = 14,
    parameter int          COL_SHIFT  = 3,
    parameter int          RST_STRIDE = 80,
    parameter logic [4:0]  RST_CHARH  = 5'd7
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic [4:0]        iCharH,
    input  logic [ADDR_W-1:0] iStride,
    input  logic [ADDR_W-1:0] iStartAddr,
    input  logic              iDblScan,
    input  logic [ADDR_W-1:0] iCursorAddr,
    input  logic [4:0]        iCursorStart,
    input  logic [4:0]        iCursorEnd,
    input  logic [1:0]        iCursorMode,
    input  logic              iLpen,
    input  logic              iLpenClr,
    output logic [ADDR_W-1:0] oAddr,
    output logic [4:0]        oRA,
    output logic [3:0]        oDA,
    output logic              oHs,
    output logic              oVs,
    output logic              oBlank,
    output logic              oRetrace,
    output logic              oCursor,
    output logic              oBlink,
    output logic [ADDR_W-1:0] oLpenAddr,
    output logic              oLpenValid
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int XW    = $clog2(H_TOT);
    localparam int YW    = $clog2(V_TOT);

    localparam logic [XW-1:0] X_LAST = XW'(H_TOT - 1);
    localparam logic [XW-1:0] X_VIS  = XW'(H_VIS);
    localparam logic [XW-1:0] X_HS0  = XW'(H_VIS + H_FP);
    localparam logic [XW-1:0] X_HS1  = XW'(H_VIS + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOT - 1);
    localparam logic [YW-1:0] Y_VIS  = YW'(V_VIS);
    localparam logic [YW-1:0] Y_VS0  = YW'(V_VIS + V_FP);
    localparam logic [YW-1:0] Y_VS1  = YW'(V_VIS + V_FP + V_SYNC);

    // Beam position and line/row tracking state
    logic [XW-1:0]     x, xN;
    logic [YW-1:0]     y, yN;
    logic [4:0]        ra, raN;
    logic              scanPhase, scanPhaseN;   // second copy of a double-scanned line
    logic [ADDR_W-1:0] rowAddr, rowAddrN;
    logic [4:0]        blinkCnt, blinkCntN;

    // Shadows: frozen across the visible region to avoid mid-frame tearing
    logic [4:0]        shCharH;
    logic [ADDR_W-1:0] shStride;
    logic [ADDR_W-1:0] shStart;

    // Next-cycle output values; registering these keeps outputs aligned to (x,y)
    logic [ADDR_W-1:0] addrN;
    logic              blankN, hsN, vsN, retraceN, cursorN, modeGate;

    // NOTE: every signal gets a default at the top of an always_comb so that no
    // path leaves it unassigned; otherwise a latch is inferred.
    always_comb begin
        xN         = x + 1'b1;
        yN         = y;
        raN        = ra;
        scanPhaseN = scanPhase;
        rowAddrN   = rowAddr;
        modeGate   = 1'b0;

        if (x == X_LAST) begin
            xN = '0;
            if (y == Y_LAST) begin
                yN         = '0;
                raN        = '0;
                scanPhaseN = 1'b0;
                rowAddrN   = shStart;
            end else begin
                yN         = y + 1'b1;
                scanPhaseN = iDblScan & ~scanPhase;
                // Logical line advances on every line, or every second one when double-scanning
                if (!iDblScan || scanPhase) begin
                    if (ra >= shCharH) begin
                        raN      = '0;
                        rowAddrN = rowAddr + shStride;
                    end else begin
                        raN = ra + 1'b1;
                    end
                end
            end
        end

        // Address wraps modulo 2^ADDR_W by truncation
        addrN     = rowAddrN + ADDR_W'(xN >> COL_SHIFT);
        blankN    = (xN >= X_VIS) || (yN >= Y_VIS);
        hsN       = ((xN >= X_HS0) && (xN < X_HS1)) ? H_POL : ~H_POL;
        vsN       = ((yN >= Y_VS0) && (yN < Y_VS1)) ? V_POL : ~V_POL;
        retraceN  = (xN == X_LAST) && (yN == Y_LAST);
        blinkCntN = blinkCnt + {4'd0, oRetrace};

        case (iCursorMode)
            2'b00:   modeGate = 1'b1;
            2'b01:   modeGate = 1'b0;
            2'b10:   modeGate = blinkCntN[3];
            default: modeGate = blinkCntN[4];
        endcase

        cursorN = !blankN && (addrN == iCursorAddr) &&
                  (raN >= iCursorStart) && (raN <= iCursorEnd) && modeGate;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            x         <= '0;
            y         <= '0;
            ra        <= '0;
            scanPhase <= 1'b0;
            rowAddr   <= '0;
            blinkCnt  <= '0;
            shCharH   <= RST_CHARH;
            shStride  <= ADDR_W'(RST_STRIDE);
            shStart   <= '0;
            oAddr     <= '0;
            oRA       <= '0;
            oDA       <= '0;
            oBlank    <= 1'b0;
            oHs       <= ~H_POL;
            oVs       <= ~V_POL;
            oRetrace  <= 1'b0;
            oCursor   <= 1'b0;
        end else begin
            x         <= xN;
            y         <= yN;
            ra        <= raN;
            scanPhase <= scanPhaseN;
            rowAddr   <= rowAddrN;
            blinkCnt  <= blinkCntN;
            if (y >= Y_VIS) begin
                shCharH  <= iCharH;
                shStride <= iStride;
                shStart  <= iStartAddr;
            end
            oAddr    <= addrN;
            oRA      <= raN;
            oDA      <= 4'(xN);
            oBlank   <= blankN;
            oHs      <= hsN;
            oVs      <= vsN;
            oRetrace <= retraceN;
            oCursor  <= cursorN;
        end
    end

    assign oBlink = blinkCnt[4];

`ifdef VIDEO_CRTC_LPEN_EN
    // Strobe is asynchronous to the pixel clock: two-flop synchroniser, then edge detect
    logic lpSync1, lpSync2, lpPrev;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            lpSync1    <= 1'b0;
            lpSync2    <= 1'b0;
            lpPrev     <= 1'b0;
            oLpenAddr  <= '0;
            oLpenValid <= 1'b0;
        end else begin
            lpSync1 <= iLpen;
            lpSync2 <= lpSync1;
            lpPrev  <= lpSync2;
            if (iLpenClr) begin
                oLpenValid <= 1'b0;
            end else if (lpSync2 && !lpPrev && !oLpenValid) begin
                oLpenValid <= 1'b1;
                oLpenAddr  <= oAddr;
            end
        end
    end
`else
    logic unusedLpen;
    assign unusedLpen = iLpen ^ iLpenClr;
    assign oLpenAddr  = '0;
    assign oLpenValid = 1'b0;
`endif

endmodule

// File: tb/tb_video_crtc_prog.sv
// -----------------------------------------------------------------------------
// tb_video_crtc_prog
//   Directed bench for video_crtc_prog on a reduced 48x30 raster
//   (H: 40 vis, 2 fp, 4 sync, 2 bp; V: 24 vis, 2 fp, 2 sync, 2 bp; COL_SHIFT=1)
//   so many frames fit in a short run. The bench tracks the beam position
//   itself and compares outputs on the falling edge.
// -----------------------------------------------------------------------------
module tb_video_crtc_prog;

    localparam int H_TOT = 48;
    localparam int V_TOT = 30;

`ifdef VIDEO_CRTC_LPEN_EN
    localparam bit LPEN = 1'b1;
`else
    localparam bit LPEN = 1'b0;
`endif

    logic        iClk;
    logic        iRstN;
    logic [4:0]  iCharH;
    logic [13:0] iStride;
    logic [13:0] iStartAddr;
    logic        iDblScan;
    logic [13:0] iCursorAddr;
    logic [4:0]  iCursorStart;
    logic [4:0]  iCursorEnd;
    logic [1:0]  iCursorMode;
    logic        iLpen;
    logic        iLpenClr;
    logic [13:0] oAddr;
    logic [4:0]  oRA;
    logic [3:0]  oDA;
    logic        oHs, oVs, oBlank, oRetrace, oCursor, oBlink;
    logic [13:0] oLpenAddr;
    logic        oLpenValid;

    video_crtc_prog #(
        .H_VIS(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b0), .V_POL(1'b1), .ADDR_W(14), .COL_SHIFT(1),
        .RST_STRIDE(80), .RST_CHARH(5'd7)
    ) dut (
        .iClk(iClk), .iRstN(iRstN), .iCharH(iCharH), .iStride(iStride),
        .iStartAddr(iStartAddr), .iDblScan(iDblScan), .iCursorAddr(iCursorAddr),
        .iCursorStart(iCursorStart), .iCursorEnd(iCursorEnd), .iCursorMode(iCursorMode),
        .iLpen(iLpen), .iLpenClr(iLpenClr), .oAddr(oAddr), .oRA(oRA), .oDA(oDA),
        .oHs(oHs), .oVs(oVs), .oBlank(oBlank), .oRetrace(oRetrace), .oCursor(oCursor),
        .oBlink(oBlink), .oLpenAddr(oLpenAddr), .oLpenValid(oLpenValid)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Bench-side beam position: (0,0) during reset, advances on every edge after
    int frameCnt, ym, xm;
    always @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            xm <= 0; ym <= 0; frameCnt <= 0;
        end else if (xm == H_TOT - 1) begin
            xm <= 0;
            if (ym == V_TOT - 1) begin
                ym <= 0;
                frameCnt <= frameCnt + 1;
            end else begin
                ym <= ym + 1;
            end
        end else begin
            xm <= xm + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int retraceSeen = 0;
    int retraceBad  = 0;

    always @(negedge iClk) begin
        if (iRstN && oRetrace) begin
            retraceSeen++;
            if (!(xm == H_TOT - 1 && ym == V_TOT - 1)) retraceBad++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the falling edge at which the bench position equals (fr,y,x)
    task automatic waitPos(input int fr, input int y, input int x);
        int budget = 60000;
        do begin
            @(negedge iClk);
            budget--;
        end while (!(frameCnt == fr && ym == y && xm == x) && budget > 0);
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL waitPos f%0d y%0d x%0d: timed out", fr, y, x);
        end
    endtask

    task automatic chkAddrRa(input int fr, input int y, input int x,
                             input logic [13:0] addr, input logic [4:0] ra);
        waitPos(fr, y, x);
        check($sformatf("addr f%0d y%0d x%0d", fr, y, x), 32'(oAddr), 32'(addr));
        check($sformatf("ra f%0d y%0d x%0d", fr, y, x), 32'(oRA), 32'(ra));
    endtask

    task automatic chkCursor(input int fr, input int y, input int x, input logic exp);
        waitPos(fr, y, x);
        check($sformatf("cursor f%0d y%0d x%0d", fr, y, x), 32'(oCursor), 32'(exp));
    endtask

    task automatic chkLpen(input int fr, input int y, input int x,
                           input logic valid, input logic [13:0] addr);
        waitPos(fr, y, x);
        check($sformatf("lpenValid f%0d y%0d x%0d", fr, y, x), 32'(oLpenValid), 32'(valid));
        check($sformatf("lpenAddr f%0d y%0d x%0d", fr, y, x), 32'(oLpenAddr), 32'(addr));
    endtask

    typedef struct {
        int          fr;
        int          y;
        int          x;
        logic [13:0] addr;
        logic [4:0]  ra;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        ret;
    } vec_t;

    vec_t vecs[20];

    initial begin
        // Frame 0: charH=7, stride=80, start=0, single scan
        vecs[0]  = '{0,  0,  0, 14'd0,   5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{0,  0,  1, 14'd0,   5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{0,  0,  2, 14'd1,   5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{0,  0, 39, 14'd19,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{0,  0, 40, 14'd20,  5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{0,  0, 41, 14'd20,  5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{0,  0, 42, 14'd21,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{0,  0, 45, 14'd22,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{0,  0, 46, 14'd23,  5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{0,  0, 47, 14'd23,  5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{0,  7,  5, 14'd2,   5'd7, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{0,  8,  0, 14'd80,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{0, 16,  8, 14'd164, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{0, 23, 39, 14'd179, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{0, 24,  0, 14'd240, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{0, 25, 44, 14'd262, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{0, 26,  0, 14'd240, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{0, 27, 10, 14'd245, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{0, 28,  0, 14'd240, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{0, 29, 47, 14'd263, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1};

        iRstN        = 1'b0;
        iCharH       = 5'd7;
        iStride      = 14'd80;
        iStartAddr   = 14'd0;
        iDblScan     = 1'b0;
        iCursorAddr  = 14'h3FFF;
        iCursorStart = 5'd0;
        iCursorEnd   = 5'd0;
        iCursorMode  = 2'b01;
        iLpen        = 1'b0;
        iLpenClr     = 1'b0;

        repeat (3) @(negedge iClk);
        check("rst oAddr", 32'(oAddr), 32'd0);
        check("rst oRA", 32'(oRA), 32'd0);
        check("rst oDA", 32'(oDA), 32'd0);
        check("rst oBlank", 32'(oBlank), 32'd0);
        check("rst oHs", 32'(oHs), 32'd1);
        check("rst oVs", 32'(oVs), 32'd0);
        check("rst oRetrace", 32'(oRetrace), 32'd0);
        check("rst oCursor", 32'(oCursor), 32'd0);
        check("rst oBlink", 32'(oBlink), 32'd0);
        check("rst oLpenAddr", 32'(oLpenAddr), 32'd0);
        check("rst oLpenValid", 32'(oLpenValid), 32'd0);

        // Release just after a rising edge so (0,0) is seen at the next falling edge
        @(posedge iClk);
        #1 iRstN = 1'b1;

        for (int i = 0; i < 20; i++) begin
            waitPos(vecs[i].fr, vecs[i].y, vecs[i].x);
            check($sformatf("v%0d oAddr", i), 32'(oAddr), 32'(vecs[i].addr));
            check($sformatf("v%0d oRA", i), 32'(oRA), 32'(vecs[i].ra));
            check($sformatf("v%0d oDA", i), 32'(oDA), 32'(vecs[i].x % 16));
            check($sformatf("v%0d oBlank", i), 32'(oBlank), 32'(vecs[i].blank));
            check($sformatf("v%0d oHs", i), 32'(oHs), 32'(vecs[i].hs));
            check($sformatf("v%0d oVs", i), 32'(oVs), 32'(vecs[i].vs));
            check($sformatf("v%0d oRetrace", i), 32'(oRetrace), 32'(vecs[i].ret));
        end

        // Frame 1: double scan, row address steps every second line
        iDblScan = 1'b1;
        chkAddrRa(1, 0, 0, 14'd0, 5'd0);
        check("f1 retrace low", 32'(oRetrace), 32'd0);
        chkAddrRa(1, 1, 0, 14'd0, 5'd0);
        chkAddrRa(1, 2, 0, 14'd0, 5'd1);
        chkAddrRa(1, 3, 4, 14'd2, 5'd1);
        chkAddrRa(1, 14, 0, 14'd0, 5'd7);
        chkAddrRa(1, 15, 0, 14'd0, 5'd7);
        chkAddrRa(1, 16, 0, 14'd80, 5'd0);
        chkAddrRa(1, 17, 6, 14'd83, 5'd0);
        waitPos(1, 20, 0);
        iDblScan = 1'b0;

        // Frame 2: start address changed mid-frame must not affect this frame
        waitPos(2, 10, 0);
        iStartAddr = 14'h3FF0;
        chkAddrRa(2, 12, 0, 14'd80, 5'd4);
        chkAddrRa(2, 23, 0, 14'd160, 5'd7);

        // Frame 3: scrolled start, address wraps silently; charH change deferred
        chkAddrRa(3, 0, 0, 14'h3FF0, 5'd0);
        chkAddrRa(3, 0, 30, 14'h3FFF, 5'd0);
        chkAddrRa(3, 0, 32, 14'h0000, 5'd0);
        waitPos(3, 2, 0);
        iCharH = 5'd3;
        chkAddrRa(3, 5, 0, 14'h3FF0, 5'd5);
        chkAddrRa(3, 8, 0, 14'h0040, 5'd0);
        waitPos(3, 25, 0);
        iStartAddr = 14'd0;
        iStride    = 14'd40;

        // Frame 4: charH=3, stride=40 now in effect
        chkAddrRa(4, 3, 0, 14'd0, 5'd3);
        chkAddrRa(4, 4, 0, 14'd40, 5'd0);
        chkAddrRa(4, 5, 2, 14'd41, 5'd1);
        chkAddrRa(4, 8, 0, 14'd80, 5'd0);
        waitPos(4, 25, 0);
        iCharH       = 5'd7;
        iStride      = 14'd80;
        iCursorAddr  = 14'd85;
        iCursorStart = 5'd6;
        iCursorEnd   = 5'd7;
        iCursorMode  = 2'b00;

        // Frame 5: steady cursor at address 85, scanlines 6..7 (y=14,15, x=10,11)
        chkCursor(5, 13, 10, 1'b0);
        chkCursor(5, 14, 9, 1'b0);
        chkCursor(5, 14, 10, 1'b1);
        chkCursor(5, 14, 11, 1'b1);
        chkCursor(5, 14, 12, 1'b0);
        chkCursor(5, 15, 11, 1'b1);
        chkCursor(5, 16, 10, 1'b0);
        check("f5 oBlink", 32'(oBlink), 32'd0);
        waitPos(5, 20, 0);
        iCursorMode = 2'b01;
        chkCursor(6, 14, 10, 1'b0);
        waitPos(6, 20, 0);
        iCursorMode = 2'b10;
        chkCursor(7, 14, 10, 1'b0);
        chkCursor(8, 14, 10, 1'b1);
        chkCursor(8, 15, 11, 1'b1);
        waitPos(8, 20, 0);
        iCursorMode  = 2'b00;
        iCursorStart = 5'd7;
        iCursorEnd   = 5'd6;
        chkCursor(9, 14, 10, 1'b0);
        chkCursor(9, 15, 10, 1'b0);
        waitPos(9, 20, 0);
        iCursorMode  = 2'b11;
        iCursorStart = 5'd6;
        iCursorEnd   = 5'd7;
        chkCursor(15, 14, 10, 1'b0);
        check("f15 oBlink", 32'(oBlink), 32'd0);
        chkCursor(16, 14, 10, 1'b1);
        chkCursor(16, 14, 12, 1'b0);
        chkCursor(16, 15, 11, 1'b1);
        check("f16 oBlink", 32'(oBlink), 32'd1);

        // Frame 17: light-pen strobes (expected zero when the feature is absent)
        waitPos(17, 8, 16);
        iLpen = 1'b1;
        waitPos(17, 8, 17);
        iLpen = 1'b0;
        chkLpen(17, 9, 0, LPEN, LPEN ? 14'd89 : 14'd0);
        waitPos(17, 10, 4);
        iLpen = 1'b1;
        waitPos(17, 10, 5);
        iLpen = 1'b0;
        chkLpen(17, 11, 0, LPEN, LPEN ? 14'd89 : 14'd0);
        waitPos(17, 12, 0);
        iLpenClr = 1'b1;
        waitPos(17, 12, 1);
        iLpenClr = 1'b0;
        check("lpen cleared", 32'(oLpenValid), 32'd0);
        waitPos(17, 13, 0);
        iLpenClr = 1'b1;
        iLpen    = 1'b1;
        waitPos(17, 13, 1);
        iLpen = 1'b0;
        waitPos(17, 13, 5);
        iLpenClr = 1'b0;
        chkLpen(17, 13, 8, 1'b0, LPEN ? 14'd89 : 14'd0);
        waitPos(17, 14, 0);
        iLpen = 1'b1;
        waitPos(17, 14, 1);
        iLpen = 1'b0;
        chkLpen(17, 14, 6, LPEN, LPEN ? 14'd81 : 14'd0);

        // One retrace per completed frame, each at the frame-wrap position
        check("retrace count", 32'(retraceSeen), 32'(frameCnt));
        check("retrace position", 32'(retraceBad), 32'd0);

        // Mid-frame reset returns everything to reset state, restarting at (0,0)
        waitPos(17, 20, 0);
        iRstN = 1'b0;
        @(negedge iClk);
        check("midrst oAddr", 32'(oAddr), 32'd0);
        check("midrst oRA", 32'(oRA), 32'd0);
        check("midrst oBlink", 32'(oBlink), 32'd0);
        check("midrst oHs", 32'(oHs), 32'd1);
        check("midrst oVs", 32'(oVs), 32'd0);
        check("midrst oLpenValid", 32'(oLpenValid), 32'd0);
        @(posedge iClk);
        #1 iRstN = 1'b1;
        chkAddrRa(0, 0, 0, 14'd0, 5'd0);
        chkAddrRa(0, 0, 5, 14'd2, 5'd0);
        chkAddrRa(0, 8, 0, 14'd80, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_crtc_prog.md
Name: video_crtc_prog

Overview:
- Parametrised, run-time-programmable CRTC timing/address generator for the video subsystem.
- Successor to the fixed 640x400 text/gfx CRTC:
  - all timing is set by parameters;
  - character height, row stride, start address (hardware scroll), double-scan and cursor are programmable;
  - cursor and blink generation are built in.
- Sits between the CPU-side register file (in the CGA/MDA front end) and video RAM/font/palette pipeline. Single clock domain (pixel clock).

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VIS, 400, visible lines
- V_FP, 12, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 35, vertical back porch
- H_POL, 0, hsync active level
- V_POL, 1, vsync active level
- ADDR_W, 14, character address width
- COL_SHIFT, 3, log2 pixels per address step
- RST_STRIDE, 80, stride after reset
- RST_CHARH, 7, char height-1 after reset

Ports:
- iClk  in  1  pixel clock
- iRstN  in  1  async active-low reset
- iCharH  in  5  character height-1 (scanlines)
- iStride  in  ADDR_W  address increment per character row
- iStartAddr  in  ADDR_W  frame start address
- iDblScan  in  1  each logical line shown twice
- iCursorAddr  in  ADDR_W  cursor character address
- iCursorStart  in  5  first cursor scanline
- iCursorEnd  in  5  last cursor scanline
- iCursorMode  in  2  00 steady, 01 off, 10 fast blink, 11 slow blink
- iLpen  in  1  light-pen strobe (optional feature)
- iLpenClr  in  1  clear light-pen latch (optional feature)
- oAddr  out  ADDR_W  character/byte address
- oRA  out  5  row address within character
- oDA  out  4  dot address (xcount[3:0])
- oHs  out  1  hsync
- oVs  out  1  vsync
- oBlank  out  1  outside visible area
- oRetrace  out  1  one-cycle frame-end strobe
- oCursor  out  1  cursor active at current address
- oBlink  out  1  slow blink phase for attribute blink
- oLpenAddr  out  ADDR_W  latched light-pen address
- oLpenValid  out  1  light-pen latch full

Behaviour:

Counters and timing:
- H_TOT = H_VIS+H_FP+H_SYNC+H_BP; V_TOT likewise.
- x runs 0..H_TOT-1; y increments when x wraps and runs 0..V_TOT-1.
- All outputs are registered and aligned to (x,y), with zero extra latency. No combinational path from any input to any output.
- oBlank = (x>=H_VIS)|(y>=V_VIS).
- oHs = H_POL when H_VIS+H_FP <= x < H_VIS+H_FP+H_SYNC, else !H_POL. oVs is analogous on y.

Shadow registers (charH, stride, start):
- Load from inputs every cycle while y>=V_VIS.
- Hold constant for the whole visible region, so no mid-frame tearing.
- iDblScan and cursor inputs are used live.

Line and address tracking:
- Logical line counter L advances at the end of each physical line. With iDblScan=1 it advances only on every second physical line.
- oRA = L modulo (charH+1); it wraps to 0 after charH.
- rowAddr += stride at the end of the final physical line of a row whose oRA==charH.
- At frame wrap (x=H_TOT-1, y=V_TOT-1): rowAddr <= shadow start, L <= 0, oRA <= 0.
- oAddr = (rowAddr + (x>>COL_SHIFT)) mod 2^ADDR_W. It wraps silently (e.g. start=0x3FF0 → column 16 reads 0x0000).
- charH changed during visible area: ignored until blank.

Retrace and blink:
- oRetrace = 1 for exactly one cycle at frame wrap.
- 5-bit blink counter increments on each oRetrace.
- oBlink = counter[4].

Cursor:
- oCursor = !oBlank & oAddr==iCursorAddr & iCursorStart<=oRA<=iCursorEnd & mode gate.
- Mode gate: 00→1, 01→0, 10→counter[3], 11→counter[4].
- Start>End → never shown.

Reset (async, iRstN=0):
- x=y=0, L=0, rowAddr=0, blink=0.
- Shadows: start 0, stride RST_STRIDE, charH RST_CHARH.
- Outputs: oAddr=0, oRA=0, oDA=0, oBlank=0, oHs=!H_POL, oVs=!V_POL, oRetrace=0, oCursor=0, oBlink=0, oLpenAddr=0, oLpenValid=0.
- Reset mid-frame restarts at (0,0) on the first edge after release.

Optional Feature:
VIDEO_CRTC_LPEN_EN:
- Defined:
  - iLpen is synchronised through 2 flops.
  - A rising edge while oLpenValid=0 latches the current oAddr into oLpenAddr and sets oLpenValid.
  - Further strobes are ignored until iLpenClr=1, which clears oLpenValid the next cycle.
  - Clear and strobe in the same cycle: clear wins.
- Undefined: iLpen/iLpenClr are ignored; oLpenAddr=0 and oLpenValid=0 constantly.

Test Plan:
1. Reset release, defaults → oHs low at x=656..751 only, oVs high at y=412..413, H_TOT=800, V_TOT=449, oRetrace pulses every 359200 cycles.
2. charH=7, stride=80, start=0 → line 8 x=0 oAddr=80; line 16 x=8 oAddr=161; oRA cycles 0..7.
3. iDblScan=1, charH=7 → oRA steps every 2 lines; oAddr=80 first at y=16.
4. iStartAddr changed 0→0x3FF0 at y=100 → frame unaffected; next frame y=0 x=0 oAddr=0x3FF0, x=128 oAddr=0x0000.
5. cursor addr=85, start=6, end=7, mode=11 → oCursor high at y=14..15, x=40..47 only on frames where blink[4]=1; mode=01 → never.
6. With VIDEO_CRTC_LPEN_EN, iLpen pulse at y=8, x=16 → oLpenAddr=82 (allowing 2-cycle sync), oLpenValid=1; second pulse ignored; iLpenClr → valid=0.
